// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: word/register types, writeback
// source and load size encodings, and the MEM/WB latch record.
package writeback_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_LUI  = 2'd3
    } wbsrc_t;

    typedef enum logic [1:0] {
        LS_WORD = 2'd0,
        LS_HALF = 2'd1,
        LS_BYTE = 2'd2
    } lsize_t;

    // Contents of the MEM/WB pipeline latch. An all-zero value is a bubble.
    typedef struct packed {
        logic        valid;
        logic        regwen;
        regbits_t    wsel;
        wbsrc_t      wbsrc;
        lsize_t      lsize;
        logic        lsigned;
        word_t       alu_out;
        word_t       dload;
        word_t       pc4;
        logic [15:0] imm16;
        logic        halt;
    } wb_latch_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-stage inputs and register-file / forwarding / status outputs of the
// writeback stage. The slave side is the writeback stage itself.
interface writeback_stage_if #(
    parameter int unsigned CNT_W = 32
) ();
    import writeback_stage_pkg::*;

    logic             wb_en;
    logic             wb_flush;
    logic             mem_valid;
    logic             mem_regwen;
    regbits_t         mem_wsel;
    wbsrc_t           mem_wbsrc;
    lsize_t           mem_lsize;
    logic             mem_lsigned;
    word_t            mem_alu_out;
    word_t            mem_dload;
    word_t            mem_pc4;
    logic [15:0]      mem_imm16;
    logic             mem_halt;

    logic             rf_WEN;
    regbits_t         rf_wsel;
    word_t            rf_wdat;
    logic             fwd_wen;
    regbits_t         fwd_wsel;
    word_t            fwd_wdat;
    logic             halt;
    logic [CNT_W-1:0] retired;

    modport master (
        output wb_en, wb_flush, mem_valid, mem_regwen, mem_wsel, mem_wbsrc,
               mem_lsize, mem_lsigned, mem_alu_out, mem_dload, mem_pc4,
               mem_imm16, mem_halt,
        input  rf_WEN, rf_wsel, rf_wdat, fwd_wen, fwd_wsel, fwd_wdat,
               halt, retired
    );

    modport slave (
        input  wb_en, wb_flush, mem_valid, mem_regwen, mem_wsel, mem_wbsrc,
               mem_lsize, mem_lsigned, mem_alu_out, mem_dload, mem_pc4,
               mem_imm16, mem_halt,
        output rf_WEN, rf_wsel, rf_wdat, fwd_wen, fwd_wsel, fwd_wdat,
               halt, retired
    );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Combinational load data formatter: selects the addressed byte/halfword
// of the raw memory word and zero- or sign-extends it to a full word.
module load_formatter
    import writeback_stage_pkg::*;
(
    input  word_t      dload_i,
    input  logic [1:0] offset_i,
    input  lsize_t     lsize_i,
    input  logic       lsigned_i,
    output word_t      data_o
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Lane selection and extension by access size.
    always_comb begin
        half_v = offset_i[1] ? dload_i[31:16] : dload_i[15:0];
        case (offset_i)
            2'd0:    byte_v = dload_i[7:0];
            2'd1:    byte_v = dload_i[15:8];
            2'd2:    byte_v = dload_i[23:16];
            default: byte_v = dload_i[31:24];
        endcase
        case (lsize_i)
            LS_HALF: data_o = {{16{lsigned_i & half_v[15]}}, half_v};
            LS_BYTE: data_o = {{24{lsigned_i & byte_v[7]}}, byte_v};
            default: data_o = dload_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch with writeback source selection, register-file write port,
// forwarding tap, sticky halt flag and retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic              CLK,
    input logic              nRST,
    writeback_stage_if.slave bus
);

    wb_latch_t        latch_q, latch_d;
    logic             counted_q, counted_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    word_t            load_data;
    word_t            wdat;
    logic             wen;

    load_formatter u_load_formatter (
        .dload_i   (latch_q.dload),
        .offset_i  (latch_q.alu_out[1:0]),
        .lsize_i   (latch_q.lsize),
        .lsigned_i (latch_q.lsigned),
        .data_o    (load_data)
    );

    // Next-state for latch, counted flag, halt flag and retired counter.
    // An instruction is counted once on its first cycle in WB; the counted
    // flag stops stalled repeats from being counted again.
    always_comb begin
        latch_d   = latch_q;
        counted_d = counted_q | (latch_q.valid & ~halt_q);
        halt_d    = halt_q | (latch_q.valid & latch_q.halt);
        retired_d = retired_q;
        if (latch_q.valid && !halt_q && !counted_q) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (halt_q) begin
            latch_d = latch_q;
        end else if (bus.wb_flush) begin
            latch_d   = '0;
            counted_d = 1'b0;
        end else if (bus.wb_en) begin
            latch_d.valid   = bus.mem_valid;
            latch_d.regwen  = bus.mem_regwen;
            latch_d.wsel    = bus.mem_wsel;
            latch_d.wbsrc   = bus.mem_wbsrc;
            latch_d.lsize   = bus.mem_lsize;
            latch_d.lsigned = bus.mem_lsigned;
            latch_d.alu_out = bus.mem_alu_out;
            latch_d.dload   = bus.mem_dload;
            latch_d.pc4     = bus.mem_pc4;
            latch_d.imm16   = bus.mem_imm16;
            latch_d.halt    = bus.mem_halt;
            counted_d       = 1'b0;
        end
    end

    // State registers, asynchronously cleared by nRST.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            latch_q   <= '0;
            counted_q <= 1'b0;
            halt_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            latch_q   <= latch_d;
            counted_q <= counted_d;
            halt_q    <= halt_d;
            retired_q <= retired_d;
        end
    end

    // Writeback data select and write enable; HALT and $0 never write.
    always_comb begin
        case (latch_q.wbsrc)
            WB_LOAD: wdat = load_data;
            WB_PC4:  wdat = latch_q.pc4;
            WB_LUI:  wdat = {latch_q.imm16, 16'h0000};
            default: wdat = latch_q.alu_out;
        endcase
        wen = latch_q.valid & latch_q.regwen & (latch_q.wsel != '0)
              & ~halt_q & ~latch_q.halt;
    end

    assign bus.rf_WEN   = wen;
    assign bus.rf_wsel  = latch_q.wsel;
    assign bus.rf_wdat  = wdat;
    assign bus.fwd_wen  = wen;
    assign bus.fwd_wsel = latch_q.wsel;
    assign bus.fwd_wdat = wdat;
    assign bus.halt     = halt_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases followed by
// randomized traffic, compared against a behavioural model of WB.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic CLK;
    logic nRST;

    writeback_stage_if #(.CNT_W(32)) bus ();
    writeback_stage_if #(.CNT_W(4))  bus4 ();

    writeback_stage #(.CNT_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    writeback_stage #(.CNT_W(4)) dut4 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus4)
    );

    assign bus4.wb_en       = bus.wb_en;
    assign bus4.wb_flush    = bus.wb_flush;
    assign bus4.mem_valid   = bus.mem_valid;
    assign bus4.mem_regwen  = bus.mem_regwen;
    assign bus4.mem_wsel    = bus.mem_wsel;
    assign bus4.mem_wbsrc   = bus.mem_wbsrc;
    assign bus4.mem_lsize   = bus.mem_lsize;
    assign bus4.mem_lsigned = bus.mem_lsigned;
    assign bus4.mem_alu_out = bus.mem_alu_out;
    assign bus4.mem_dload   = bus.mem_dload;
    assign bus4.mem_pc4     = bus.mem_pc4;
    assign bus4.mem_imm16   = bus.mem_imm16;
    assign bus4.mem_halt    = bus.mem_halt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: the instruction currently in WB, plus halt and retire count.
    logic        m_valid, m_regwen, m_lsigned, m_hinstr, m_halt, m_fresh;
    logic [4:0]  m_wsel;
    wbsrc_t      m_wbsrc;
    lsize_t      m_lsize;
    logic [31:0] m_alu, m_dload, m_pc4;
    logic [15:0] m_imm;
    longint unsigned m_retired;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load();
        longint unsigned off, v, lim;
        off = longint'(m_alu % 4);
        if (m_lsize == LS_HALF) begin
            v   = (longint'(m_dload) / (longint'(1) << (16 * (off / 2)))) % 65536;
            lim = 32768;
        end else if (m_lsize == LS_BYTE) begin
            v   = (longint'(m_dload) / (longint'(1) << (8 * off))) % 256;
            lim = 128;
        end else begin
            return m_dload;
        end
        if (m_lsigned && v >= lim) v = v + (longint'(1) << 32) - 2 * lim;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_wdat();
        case (m_wbsrc)
            WB_LOAD: return model_load();
            WB_PC4:  return m_pc4;
            WB_LUI:  return {m_imm, 16'h0000};
            default: return m_alu;
        endcase
    endfunction

    function automatic logic model_wen();
        return m_valid && m_regwen && m_wsel != 0 && !m_halt && !m_hinstr;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_regwen = 0; m_lsigned = 0; m_hinstr = 0; m_fresh = 0;
        m_wsel = 0; m_wbsrc = WB_ALU; m_lsize = LS_WORD;
        m_alu = 0; m_dload = 0; m_pc4 = 0; m_imm = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".wen"},   bus.rf_WEN,   model_wen());
        check_eq({tag, ".wsel"},  bus.rf_wsel,  m_wsel);
        check_eq({tag, ".wdat"},  bus.rf_wdat,  model_wdat());
        check_eq({tag, ".fwen"},  bus.fwd_wen,  model_wen());
        check_eq({tag, ".fwsel"}, bus.fwd_wsel, m_wsel);
        check_eq({tag, ".fwdat"}, bus.fwd_wdat, model_wdat());
        check_eq({tag, ".halt"},  bus.halt,     m_halt);
        check_eq({tag, ".ret"},   bus.retired,  m_retired % (longint'(1) << 32));
        check_eq({tag, ".ret4"},  bus4.retired, m_retired % 16);
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic [4:0] ws,
                             input wbsrc_t src, input lsize_t ls, input logic sg,
                             input logic [31:0] alu, input logic [31:0] dl,
                             input logic [31:0] pc4, input logic [15:0] imm,
                             input logic h);
        bus.mem_valid = v; bus.mem_regwen = rw; bus.mem_wsel = ws;
        bus.mem_wbsrc = src; bus.mem_lsize = ls; bus.mem_lsigned = sg;
        bus.mem_alu_out = alu; bus.mem_dload = dl; bus.mem_pc4 = pc4;
        bus.mem_imm16 = imm; bus.mem_halt = h;
    endtask

    // One clock: drive enables, advance model at the edge, check #1 after.
    task automatic tick(input logic en, input logic fl, input string tag);
        logic old_halt;
        bus.wb_en = en; bus.wb_flush = fl;
        @(posedge CLK);
        old_halt = m_halt;
        if (m_valid && !m_halt && m_fresh) begin
            m_retired++;
            m_fresh = 0;
        end
        if (m_valid && m_hinstr) m_halt = 1;
        if (!old_halt) begin
            if (fl) begin
                model_clear();
                m_fresh = 1;
            end else if (en) begin
                m_valid = bus.mem_valid; m_regwen = bus.mem_regwen;
                m_wsel = bus.mem_wsel; m_wbsrc = bus.mem_wbsrc;
                m_lsize = bus.mem_lsize; m_lsigned = bus.mem_lsigned;
                m_alu = bus.mem_alu_out; m_dload = bus.mem_dload;
                m_pc4 = bus.mem_pc4; m_imm = bus.mem_imm16;
                m_hinstr = bus.mem_halt; m_fresh = 1;
            end
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges, released at the negedge.
    task automatic do_reset(input string tag);
        #2;
        nRST = 1'b0;
        #1;
        model_clear();
        m_halt = 0;
        m_retired = 0;
        check_all(tag);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b1;
        bus.wb_en = 0; bus.wb_flush = 0;
        set_instr(0, 0, 0, WB_ALU, LS_WORD, 0, 0, 0, 0, 0, 0);
        model_clear();
        m_halt = 0; m_retired = 0;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check_all("por");
        @(negedge CLK);
        nRST = 1'b1;

        // Basic ALU write, then some traffic and a mid-stall reset.
        set_instr(1, 1, 5, WB_ALU, LS_WORD, 0, 32'h1234, 0, 0, 0, 0);
        tick(1, 0, "alu");
        check_eq("alu.wdat_k", bus.rf_wdat, 32'h0000_1234);
        check_eq("alu.wen_k", bus.rf_WEN, 1'b1);
        tick(0, 0, "alu_ret");
        check_eq("alu.ret_k", bus.retired, 1);
        set_instr(1, 1, 7, WB_PC4, LS_WORD, 0, 0, 0, 32'h40, 0, 0);
        tick(1, 0, "pre_rst");
        tick(0, 0, "stall_rst");
        do_reset("rst_mid");
        check_eq("rst.wdat_k", bus.rf_wdat, 0);

        // Load formatting.
        set_instr(1, 1, 9, WB_LOAD, LS_BYTE, 1, 32'h100, 32'h80F1_7F82, 0, 0, 0);
        tick(1, 0, "ldb0s");
        check_eq("ldb0s.k", bus.rf_wdat, 32'hFFFF_FF82);
        set_instr(1, 1, 9, WB_LOAD, LS_BYTE, 0, 32'h101, 32'h80F1_7F82, 0, 0, 0);
        tick(1, 0, "ldb1u");
        check_eq("ldb1u.k", bus.rf_wdat, 32'h0000_007F);
        set_instr(1, 1, 9, WB_LOAD, LS_HALF, 1, 32'h102, 32'h80F1_7F82, 0, 0, 0);
        tick(1, 0, "ldh2s");
        check_eq("ldh2s.k", bus.rf_wdat, 32'hFFFF_80F1);
        set_instr(1, 1, 10, WB_LUI, LS_WORD, 0, 0, 0, 0, 16'hBEEF, 0);
        tick(1, 0, "lui");
        check_eq("lui.k", bus.rf_wdat, 32'hBEEF_0000);
        set_instr(1, 1, 11, WB_PC4, LS_WORD, 0, 0, 0, 32'h40, 0, 0);
        tick(1, 0, "pc4");
        check_eq("pc4.k", bus.rf_wdat, 32'h40);
        set_instr(1, 1, 0, WB_ALU, LS_WORD, 0, 32'h55, 0, 0, 0, 0);
        tick(1, 0, "r0");
        check_eq("r0.wen_k", bus.rf_WEN, 1'b0);
        check_eq("r0.wdat_k", bus.rf_wdat, 32'h55);

        // Stall three cycles, then flush with enable high.
        set_instr(1, 1, 12, WB_ALU, LS_WORD, 0, 32'hCAFE, 0, 0, 0, 0);
        tick(1, 0, "st_in");
        set_instr(1, 1, 13, WB_ALU, LS_WORD, 0, 32'hDEAD, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 3; i++) tick(0, 0, "stall");
        check_eq("stall.wdat_k", bus.rf_wdat, 32'hCAFE);
        check_eq("stall.ret_k", bus.retired, 7);
        tick(1, 1, "flush");
        check_eq("flush.wen_k", bus.rf_WEN, 1'b0);
        tick(0, 0, "flush2");
        check_eq("flush.ret_k", bus.retired, 7);

        // HALT and later writes.
        set_instr(1, 1, 3, WB_ALU, LS_WORD, 0, 32'h77, 0, 0, 0, 1);
        tick(1, 0, "halt_in");
        check_eq("halt_in.wen_k", bus.rf_WEN, 1'b0);
        set_instr(1, 1, 4, WB_ALU, LS_WORD, 0, 32'h88, 0, 0, 0, 0);
        tick(1, 0, "halt_set");
        check_eq("halt_set.k", bus.halt, 1'b1);
        for (int unsigned i = 0; i < 4; i++) tick(1, 0, "halted");
        check_eq("halted.ret_k", bus.retired, 8);
        do_reset("rst_halt");

        // Counter wrap on the 4-bit instance.
        for (int unsigned i = 0; i < 17; i++) begin
            set_instr(1, 1, 5'(i + 1), WB_ALU, LS_WORD, 0, i, 0, 0, 0, 0);
            tick(1, 0, "wrap");
        end
        tick(0, 0, "wrap_end");
        check_eq("wrap.ret4_k", bus4.retired, 1);
        check_eq("wrap.ret_k", bus.retired, 17);
        do_reset("rst_wrap");

        // Randomized traffic with periodic resets.
        for (int unsigned n = 0; n < 600; n++) begin
            logic [31:0] r;
            r = $urandom;
            set_instr(r[2:0] != 0, r[3], (r[7:4] == 0) ? 5'd0 : 5'($urandom),
                      wbsrc_t'(r[9:8]), lsize_t'($urandom_range(2, 0)), r[10],
                      $urandom, $urandom, $urandom, 16'($urandom),
                      $urandom_range(39, 0) == 0);
            tick($urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0, "rnd");
            if (n % 60 == 59) do_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
